// File: rtl/data_out.sv
// Serializes a 255-bit (x,y) point result into eight 64-bit words, X then Y, MSB word first.
// Latency: first word is valid the cycle after result fire; stalls hold word/state while i_out_ready=0.
module data_out (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_res_valid,
    input  logic [254:0] i_res_x,
    input  logic [254:0] i_res_y,
    output logic         o_res_ready,
    output logic         o_out_valid,
    output logic [63:0]  o_out_data,
    input  logic         i_out_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND_X = 2'd1,
        S_SEND_Y = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [1:0]   r_cnt;
    logic [255:0] r_x;
    logic [255:0] r_y;
    logic [255:0] w_sel;
    logic         w_res_fire;
    logic         w_word_fire;

    always_comb begin
        o_res_ready  = 1'b0;
        o_out_valid  = 1'b0;
        w_sel        = '0;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                o_res_ready = 1'b1;
                if (i_res_valid) w_next_state = S_SEND_X;
            end
            S_SEND_X: begin
                o_out_valid = 1'b1;
                w_sel       = r_x;
                if (i_out_ready && (r_cnt == 2'd3)) w_next_state = S_SEND_Y;
            end
            S_SEND_Y: begin
                o_out_valid = 1'b1;
                w_sel       = r_y;
                if (i_out_ready && (r_cnt == 2'd3)) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_res_fire  = i_res_valid & o_res_ready;
    assign w_word_fire = o_out_valid & i_out_ready;

    // w_sel is zero in idle, so the output word is zero there as well.
    always_comb begin
        case (r_cnt)
            2'd0:    o_out_data = w_sel[255:192];
            2'd1:    o_out_data = w_sel[191:128];
            2'd2:    o_out_data = w_sel[127:64];
            default: o_out_data = w_sel[63:0];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_res_fire) begin
                r_x   <= {1'b0, i_res_x};
                r_y   <= {1'b0, i_res_y};
                r_cnt <= 2'd0;
            end else if (w_word_fire) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_out.sv
// Randomized bench for data_out: a word-queue reference model predicts every output each cycle.
module tb_data_out;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_res_valid;
    logic [254:0] i_res_x;
    logic [254:0] i_res_y;
    logic         o_res_ready;
    logic         o_out_valid;
    logic [63:0]  o_out_data;
    logic         i_out_ready;

    data_out u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_res_valid (i_res_valid),
        .i_res_x     (i_res_x),
        .i_res_y     (i_res_y),
        .o_res_ready (o_res_ready),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .i_out_ready (i_out_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_vec;
    int          n_err;
    int          cyc;
    logic [63:0] q[$];
    int          fire_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [254:0] v, input int k);
        logic [255:0] t;
        t = {1'b0, v};
        t = t >> (64 * (3 - k));
        return t[63:0];
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t = {t[223:0], 32'($urandom)};
        return t[254:0];
    endfunction

    task automatic check_outputs();
        chk("res_ready", {63'd0, o_res_ready}, {63'd0, q.size() == 0});
        chk("out_valid", {63'd0, o_out_valid}, {63'd0, q.size() != 0});
        chk("out_data", o_out_data, (q.size() != 0) ? q[0] : 64'd0);
    endtask

    // One clock: apply inputs, let the edge happen, advance the model, then compare.
    task automatic step(input logic v, input logic [254:0] x, input logic [254:0] y, input logic ordy);
        i_res_valid = v;
        i_res_x     = x;
        i_res_y     = y;
        i_out_ready = ordy;
        if (o_res_ready && v) fire_cyc.push_back(cyc);
        @(posedge i_clk);
        cyc++;
        if (q.size() == 0) begin
            if (v) begin
                for (int k = 0; k < 4; k++) q.push_back(word_of(x, k));
                for (int k = 0; k < 4; k++) q.push_back(word_of(y, k));
            end
        end else if (ordy) begin
            void'(q.pop_front());
        end
        #1;
        check_outputs();
    endtask

    task automatic drain(input int max_cyc, input logic rnd_rdy);
        for (int i = 0; i < max_cyc && q.size() != 0; i++)
            step(1'b0, rand255(), rand255(), rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        chk("drained", {63'd0, o_out_valid}, 64'd0);
    endtask

    initial begin
        logic [254:0] xa, xb, ones;
        n_vec = 0; n_err = 0; cyc = 0;
        ones        = '1;
        i_rst_n     = 1'b0;
        i_res_valid = 1'b0;
        i_res_x     = '0;
        i_res_y     = '0;
        i_out_ready = 1'b0;
        #3;
        check_outputs();
        #9 i_rst_n = 1'b1;

        // basic X=1, Y=2 with ready held high
        step(1'b1, 255'h1, 255'h2, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 255'h0, 255'h0, 1'b1);
        chk("basic_ready_n9", {63'd0, o_res_ready}, 64'd1);

        // full-width operands
        step(1'b1, ones, ones, 1'b1);
        chk("full_w0", o_out_data, 64'h7FFF_FFFF_FFFF_FFFF);
        step(1'b0, 255'h0, 255'h0, 1'b1);
        chk("full_w1", o_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        drain(20, 1'b0);

        // backpressure: stall three cycles on X word 2, then random ready
        step(1'b1, rand255(), rand255(), 1'b1);
        step(1'b0, 255'h0, 255'h0, 1'b1);
        step(1'b0, 255'h0, 255'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, rand255(), rand255(), 1'b0);
        drain(200, 1'b1);

        // new results offered mid-transfer must wait for idle
        step(1'b1, rand255(), rand255(), 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, rand255(), rand255(), 1'b1);
        drain(20, 1'b0);

        // asynchronous reset after the fifth word fire
        step(1'b1, rand255(), rand255(), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 255'h0, 255'h0, 1'b1);
        #2 i_rst_n = 1'b0;
        q.delete();
        #1;
        chk("rst_async_valid", {63'd0, o_out_valid}, 64'd0);
        chk("rst_async_ready", {63'd0, o_res_ready}, 64'd1);
        chk("rst_async_data", o_out_data, 64'd0);
        @(posedge i_clk); cyc++;
        #1 check_outputs();
        @(negedge i_clk) i_rst_n = 1'b1;
        step(1'b1, 255'hA, 255'hB, 1'b1);
        drain(20, 1'b0);

        // back-to-back results with continuous valid
        fire_cyc.delete();
        xa = rand255();
        xb = rand255();
        for (int i = 0; i < 40 && fire_cyc.size() < 2; i++)
            step(1'b1, (fire_cyc.size() == 0) ? xa : xb, (fire_cyc.size() == 0) ? xb : xa, 1'b1);
        chk("b2b_fires", 64'(fire_cyc.size()), 64'd2);
        if (fire_cyc.size() == 2) chk("b2b_gap", 64'(fire_cyc[1] - fire_cyc[0]), 64'd9);
        drain(20, 1'b0);

        // random soak
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) == 0), rand255(), rand255(), 1'($urandom_range(0, 3) != 0));
        drain(200, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
